// File: rtl/ram_pkg.sv
// Shared types for the RAM burst-read streamer: FSM state encoding and output buffer depth.
package ram_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } rd_state_t;

    localparam int unsigned BUF_DEPTH = 2;

endpackage

// File: rtl/fifo_2e.sv
// Two-entry fall-through buffer: an incoming word is presented on the output in the
// same cycle when the buffer is empty, so a free-running consumer sees no extra latency.
module fifo_2e
    import ram_pkg::*;
#(
    parameter int Word_Width = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [Word_Width-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [Word_Width-1:0] out_data,
    output logic [1:0]            level
);

    logic                  wr_ptr_reg, wr_ptr_next;
    logic                  rd_ptr_reg, rd_ptr_next;
    logic [1:0]            count_reg, count_next;
    logic                  bypass, push, pop;
    logic [Word_Width-1:0] slot_data [BUF_DEPTH];

    // A word that arrives into an empty buffer while the consumer is ready is never stored.
    assign bypass    = in_valid && (count_reg == 2'd0) && out_ready;
    assign push      = in_valid && in_ready && !bypass;
    assign pop       = out_ready && (count_reg != 2'd0);
    assign in_ready  = (count_reg != 2'd2);
    assign out_valid = (count_reg != 2'd0) || in_valid;
    assign level     = count_reg;

    always_comb begin
        out_data = '0;
        if (count_reg != 2'd0) begin
            out_data = slot_data[rd_ptr_reg];
        end else if (in_valid) begin
            out_data = in_data;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < BUF_DEPTH; gi++) begin : g_slot
            logic [Word_Width-1:0] slot_reg;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    slot_reg <= '0;
                end else if (push && (wr_ptr_reg == 1'(gi))) begin
                    slot_reg <= in_data;
                end
            end
            assign slot_data[gi] = slot_reg;
        end
    endgenerate

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (push) wr_ptr_next = !wr_ptr_reg;
        if (pop)  rd_ptr_next = !rd_ptr_reg;
        if (push && !pop) begin
            count_next = count_reg + 2'd1;
        end else if (pop && !push) begin
            count_next = count_reg - 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

endmodule

// File: rtl/ram_rd_stream.sv
// Burst reader: issues sequential RAM reads and streams the words out under valid/ready.
// Define RAM_RD_STREAM_LAST_EN to add the last_o end-of-burst marker.
module ram_rd_stream
    import ram_pkg::*;
#(
    parameter int Addr_Width = 6,
    parameter int Word_Width = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [Addr_Width-1:0] base_i,
    input  logic [Addr_Width:0]   len_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  ram_cen_o,
    output logic                  ram_oen_o,
    output logic                  ram_wen_o,
    output logic [Addr_Width-1:0] ram_addr_o,
    input  logic [Word_Width-1:0] ram_data_i,
    output logic [Word_Width-1:0] data_o,
    output logic                  valid_o,
`ifdef RAM_RD_STREAM_LAST_EN
    output logic                  last_o,
`endif
    input  logic                  ready_i
);

    localparam logic [Addr_Width-1:0] ADDR_ONE = 1;
    localparam logic [Addr_Width:0]   CNT_ONE  = 1;

    rd_state_t             state_reg, state_next;
    logic [Addr_Width-1:0] addr_reg, addr_next;
    logic [Addr_Width:0]   issue_left_reg, issue_left_next;
    logic [Addr_Width:0]   out_left_reg, out_left_next;
    logic                  inflight_reg;
    logic                  done_reg, done_next;
    logic                  issue, xfer, buf_in_ready;
    logic [1:0]            buf_level;

    // Buffered words plus the read in flight must stay below two, so every returning word has a slot.
    assign issue = (state_reg == ST_READ) && buf_in_ready &&
                   ((buf_level == 2'd0) || ((buf_level == 2'd1) && !inflight_reg));
    assign xfer  = valid_o && ready_i;

    always_comb begin
        state_next      = state_reg;
        addr_next       = addr_reg;
        issue_left_next = issue_left_reg;
        out_left_next   = out_left_reg;
        done_next       = 1'b0;
        if (xfer) out_left_next = out_left_reg - CNT_ONE;
        case (state_reg)
            ST_IDLE: begin
                if (start_i) begin
                    if (len_i == '0) begin
                        done_next = 1'b1;
                    end else begin
                        state_next      = ST_READ;
                        addr_next       = base_i;
                        issue_left_next = len_i;
                        out_left_next   = len_i;
                    end
                end
            end
            ST_READ: begin
                if (issue) begin
                    addr_next       = addr_reg + ADDR_ONE;
                    issue_left_next = issue_left_reg - CNT_ONE;
                    if (issue_left_reg == CNT_ONE) state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // The final word leaving means nothing remains in flight or buffered.
                if (xfer && (out_left_reg == CNT_ONE)) begin
                    state_next = ST_IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            addr_reg       <= '0;
            issue_left_reg <= '0;
            out_left_reg   <= '0;
            inflight_reg   <= 1'b0;
            done_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            addr_reg       <= addr_next;
            issue_left_reg <= issue_left_next;
            out_left_reg   <= out_left_next;
            inflight_reg   <= issue;
            done_reg       <= done_next;
        end
    end

    fifo_2e #(
        .Word_Width(Word_Width)
    ) u_buf (
        .clk      (clk),
        .rst      (rst),
        .in_valid (inflight_reg),
        .in_ready (buf_in_ready),
        .in_data  (ram_data_i),
        .out_valid(valid_o),
        .out_ready(ready_i),
        .out_data (data_o),
        .level    (buf_level)
    );

    assign busy_o     = (state_reg != ST_IDLE);
    assign done_o     = done_reg;
    assign ram_cen_o  = !issue;
    assign ram_oen_o  = !issue;
    assign ram_wen_o  = 1'b1;
    assign ram_addr_o = addr_reg;

`ifdef RAM_RD_STREAM_LAST_EN
    assign last_o = valid_o && (out_left_reg == CNT_ONE);
`endif

endmodule

// File: tb/tb_ram_rd_stream.sv
// Self-checking bench for ram_rd_stream: table of bursts plus hand-written restart/reset sequences.
module tb_ram_rd_stream;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic [5:0]  base_i;
    logic [6:0]  len_i;
    logic        busy_o, done_o, ram_cen_o, ram_oen_o, ram_wen_o;
    logic [5:0]  ram_addr_o;
    logic [31:0] ram_data_i = 32'hDEAD_BEEF;
    logic [31:0] data_o;
    logic        valid_o;
    logic        ready_i;
`ifdef RAM_RD_STREAM_LAST_EN
    logic        last_o;
`endif

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];
    logic [5:0]  act_addr_q[$];
    int          outstanding = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data = '0;

    typedef struct {
        logic [5:0] base;
        logic [6:0] len;
        int         mode;
        int         exp_done;
        int         exp_first;
    } vec_t;
    vec_t vecs[7];

    always #5 clk = ~clk;

    ram_rd_stream dut (
        .clk       (clk),
        .rst       (rst),
        .start_i   (start_i),
        .base_i    (base_i),
        .len_i     (len_i),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .ram_cen_o (ram_cen_o),
        .ram_oen_o (ram_oen_o),
        .ram_wen_o (ram_wen_o),
        .ram_addr_o(ram_addr_o),
        .ram_data_i(ram_data_i),
        .data_o    (data_o),
        .valid_o   (valid_o),
`ifdef RAM_RD_STREAM_LAST_EN
        .last_o    (last_o),
`endif
        .ready_i   (ready_i)
    );

    function automatic logic [31:0] word_of(input logic [5:0] a);
        return {8'hA5, 2'b00, a, 8'h3C, 2'b00, a};
    endfunction

    // Synchronous-read RAM: data appears the cycle after an enabled read, junk otherwise.
    always @(posedge clk) begin
        if (!ram_cen_o) ram_data_i <= word_of(ram_addr_o);
        else            ram_data_i <= 32'hDEAD_BEEF;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic rdy(input int mode, input int cyc);
        if (mode == 0) return 1'b1;
        if (mode == 1) return ((cyc % 4) == 0) || ((cyc % 4) == 3);
        return 1'($urandom_range(0, 1));
    endfunction

    // Scoreboard monitor: checks every transfer, every issued read and every stalled cycle.
    always @(negedge clk) begin
        if (rst) begin
            outstanding = 0;
            prev_stall  = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", 32'(valid_o), 32'd1);
                chk("stall_data", data_o, prev_data);
            end
            if (!ram_cen_o) begin
                act_addr_q.push_back(ram_addr_o);
                outstanding++;
                chk("outstanding_le2", 32'(outstanding <= 2), 32'd1);
                chk("oen_with_cen", 32'(ram_oen_o), 32'd0);
                chk("wen_high", 32'(ram_wen_o), 32'd1);
            end
            if (valid_o && ready_i) begin
                chk("queue_nonempty", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
`ifdef RAM_RD_STREAM_LAST_EN
                    chk("last", 32'(last_o), 32'(exp_q.size() == 1));
`endif
                    chk("data", data_o, exp_q.pop_front());
                end
                outstanding--;
            end
            prev_stall = valid_o && !ready_i;
            prev_data  = data_o;
        end
    end

    task automatic chk_reset_state(input string tag);
        chk({tag, "_busy"},  32'(busy_o),     32'd0);
        chk({tag, "_done"},  32'(done_o),     32'd0);
        chk({tag, "_valid"}, 32'(valid_o),    32'd0);
        chk({tag, "_cen"},   32'(ram_cen_o),  32'd1);
        chk({tag, "_oen"},   32'(ram_oen_o),  32'd1);
        chk({tag, "_wen"},   32'(ram_wen_o),  32'd1);
        chk({tag, "_addr"},  32'(ram_addr_o), 32'd0);
        chk({tag, "_data"},  data_o,          32'd0);
    endtask

    task automatic run_burst(input logic [5:0] b, input logic [6:0] l, input int mode,
                             input int exp_done, input int exp_first);
        int         cyc, first_v, done_cyc;
        logic [5:0] ea;
        act_addr_q.delete();
        for (int n = 0; n < int'(l); n++) begin
            ea = b + 6'(n);
            exp_q.push_back(word_of(ea));
        end
        start_i = 1'b1; base_i = b; len_i = l; ready_i = rdy(mode, 0);
        cyc = 0; first_v = -1; done_cyc = -1;
        while (done_cyc < 0 && cyc < 300) begin
            @(negedge clk);
            if (valid_o && first_v < 0) first_v = cyc;
            if (done_o) done_cyc = cyc;
            @(posedge clk); #1;
            start_i = 1'b0;
            cyc++;
            ready_i = rdy(mode, cyc);
        end
        $display("burst base=%0d len=%0d mode=%0d done_cycle=%0d first_valid=%0d",
                 b, l, mode, done_cyc, first_v);
        chk("done_seen", 32'(done_cyc >= 0), 32'd1);
        if (exp_done > 0) chk("done_cycle", done_cyc, exp_done);
        chk("first_valid", first_v, exp_first);
        chk("words_left", 32'(exp_q.size()), 32'd0);
        chk("addr_count", 32'(act_addr_q.size()), 32'(l));
        for (int n = 0; n < act_addr_q.size() && n < int'(l); n++) begin
            ea = b + 6'(n);
            chk("addr", 32'(act_addr_q[n]), 32'(ea));
        end
        exp_q.delete();
    endtask

    // Start pulsed mid-burst (ignored) and again in the done cycle (accepted).
    task automatic seq_restart();
        int         cyc;
        logic       seen_done;
        logic [5:0] ea_list[7];
        ea_list = '{6'd8, 6'd9, 6'd10, 6'd11, 6'd20, 6'd21, 6'd22};
        act_addr_q.delete();
        for (int n = 0; n < 4; n++) exp_q.push_back(word_of(6'd8 + 6'(n)));
        start_i = 1'b1; base_i = 6'd8; len_i = 7'd4; ready_i = 1'b1;
        @(posedge clk); #1; start_i = 1'b0;
        @(posedge clk); #1; start_i = 1'b1; base_i = 6'd40; len_i = 7'd5;
        @(posedge clk); #1; start_i = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        chk("restart_done_pulse", 32'(done_o), 32'd1);
        chk("restart_busy_in_done", 32'(busy_o), 32'd0);
        for (int n = 0; n < 3; n++) exp_q.push_back(word_of(6'd20 + 6'(n)));
        start_i = 1'b1; base_i = 6'd20; len_i = 7'd3;
        @(posedge clk); #1; start_i = 1'b0;
        chk("restart_busy", 32'(busy_o), 32'd1);
        seen_done = 1'b0; cyc = 0;
        while (!seen_done && cyc < 50) begin
            @(negedge clk);
            if (done_o) seen_done = 1'b1;
            @(posedge clk); #1;
            cyc++;
        end
        $display("restart sequence: second burst done after %0d cycles", cyc);
        chk("restart_done_seen", 32'(seen_done), 32'd1);
        chk("restart_words_left", 32'(exp_q.size()), 32'd0);
        chk("restart_addr_count", 32'(act_addr_q.size()), 32'd7);
        for (int n = 0; n < act_addr_q.size() && n < 7; n++)
            chk("restart_addr", 32'(act_addr_q[n]), 32'(ea_list[n]));
        exp_q.delete();
    endtask

    // Reset asserted right after the third transfer of an 8-word burst.
    task automatic seq_reset();
        logic seen_valid, seen_cen;
        for (int n = 0; n < 8; n++) exp_q.push_back(word_of(6'd10 + 6'(n)));
        start_i = 1'b1; base_i = 6'd10; len_i = 7'd8; ready_i = 1'b1;
        repeat (5) begin @(posedge clk); #1; start_i = 1'b0; end
        chk("xfers_before_rst", 32'(8 - exp_q.size()), 32'd3);
        rst = 1'b1;
        #1;
        chk_reset_state("midburst_rst");
        exp_q.delete();
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        seen_valid = 1'b0; seen_cen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (valid_o) seen_valid = 1'b1;
            if (!ram_cen_o) seen_cen = 1'b1;
            @(posedge clk); #1;
        end
        $display("reset sequence: valid_seen=%0d read_seen=%0d", seen_valid, seen_cen);
        chk("no_valid_after_rst", 32'(seen_valid), 32'd0);
        chk("no_read_after_rst", 32'(seen_cen), 32'd0);
        chk("idle_after_rst", 32'(busy_o), 32'd0);
    endtask

    initial begin
        rst = 1'b1; start_i = 1'b0; base_i = '0; len_i = '0; ready_i = 1'b0;
        vecs[0] = '{6'd0,  7'd4,  0, 6,  2};
        vecs[1] = '{6'd62, 7'd4,  0, 6,  2};
        vecs[2] = '{6'd5,  7'd16, 1, 0,  2};
        vecs[3] = '{6'd0,  7'd0,  0, 1,  -1};
        vecs[4] = '{6'd33, 7'd64, 0, 66, 2};
        vecs[5] = '{6'd7,  7'd9,  2, 0,  2};
        vecs[6] = '{6'd63, 7'd1,  0, 3,  2};
        repeat (2) @(posedge clk);
        #1;
        chk_reset_state("reset");
        rst = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 7; i++)
            run_burst(vecs[i].base, vecs[i].len, vecs[i].mode, vecs[i].exp_done, vecs[i].exp_first);
        seq_restart();
        seq_reset();
        run_burst(6'd3, 7'd2, 0, 4, 2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ram_rd_stream.md
RAM_RD_STREAM -- requirements
Module: ram_rd_stream

Interface
REQ-001 SHALL have parameter Addr_Width, default 6, RAM address width in bits.
REQ-002 SHALL have parameter Word_Width, default 32, RAM data width in bits.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port start_i  input  1  one-cycle request to begin a burst read.
REQ-006 SHALL have port base_i  input  Addr_Width  first RAM address, sampled with start_i.
REQ-007 SHALL have port len_i  input  Addr_Width+1  burst length in words (0..2^Addr_Width), sampled with start_i.
REQ-008 SHALL have port busy_o  output  1  high from accepted start until done_o.
REQ-009 SHALL have port done_o  output  1  one-cycle pulse at burst completion.
REQ-010 SHALL have port ram_cen_o  output  1  RAM chip enable, active-low.
REQ-011 SHALL have port ram_oen_o  output  1  RAM output enable, active-low.
REQ-012 SHALL have port ram_wen_o  output  1  RAM write enable, active-low; constant 1.
REQ-013 SHALL have port ram_addr_o  output  Addr_Width  RAM address.
REQ-014 SHALL have port ram_data_i  input  Word_Width  RAM read data, valid one cycle after ram_cen_o low.
REQ-015 SHALL have port data_o  output  Word_Width  stream data.
REQ-016 SHALL have port valid_o  output  1  stream data valid.
REQ-017 SHALL have port ready_i  input  1  stream consumer ready; transfer when valid_o and ready_i both high.

Function
REQ-018 SHALL implement FSM IDLE, READ, DRAIN; IDLE->READ on start_i with len_i!=0; READ->DRAIN after last read issued; DRAIN->IDLE when last word transferred and no read in flight.
REQ-019 SHALL, on start_i with len_i==0, pulse done_o the next cycle, issue no RAM access, and stay in IDLE.
REQ-020 SHALL ignore start_i while busy_o is high.
REQ-021 SHALL drive ram_cen_o=0 and ram_oen_o=0 only in the cycle a read is issued, else both 1.
REQ-022 SHALL issue read n at address (base_i+n) modulo 2^Addr_Width, wrapping silently past the top address.
REQ-023 SHALL issue a read only if 2-entry output buffer occupancy plus reads in flight is below 2.
REQ-024 SHALL capture ram_data_i into the output buffer exactly one cycle after each issued read.
REQ-025 SHALL present words in address-issue order with no loss or duplication under any ready_i pattern.
REQ-026 SHALL sustain one word per cycle while ready_i is held high (first valid_o 2 cycles after start_i).
REQ-027 SHALL hold data_o stable while valid_o is high and ready_i is low.
REQ-028 SHALL pulse done_o the cycle after the final transfer; busy_o falls in the same cycle.
REQ-029 SHALL accept start_i in the cycle done_o is high.

Reset
REQ-030 SHALL, on rst asserted at any time including mid-burst, go to IDLE, flush buffer and in-flight tracking, and force busy_o=0, done_o=0, valid_o=0, ram_cen_o=1, ram_oen_o=1, ram_wen_o=1, ram_addr_o=0, data_o=0.
REQ-031 SHALL discard RAM data returning in the first cycle after reset release.

Configuration
REQ-032 SHALL, with RAM_RD_STREAM_LAST_EN defined, add output last_o (1 bit), high with valid_o on the final word of a burst, reset 0.
REQ-033 SHALL, without RAM_RD_STREAM_LAST_EN, have no last_o port and no associated logic.

Structure
REQ-034 SHALL take the FSM state enum typedef from shared package ram_pkg.
REQ-035 SHALL instantiate the 2-entry output buffer as sub-module fifo_2e (parameter Word_Width, valid/ready both sides).

Verification
REQ-036 SHALL cover base=0, len=4, ready_i=1: reads at 0,1,2,3 on consecutive cycles, four words out, done_o one cycle after the fourth transfer.
REQ-037 SHALL cover base=62, len=4, Addr_Width=6: addresses 62,63,0,1 in order.
REQ-038 SHALL cover len=16 with ready_i toggling 1,0,0,1 repeating: all 16 words in order, data_o stable while stalled, at most 2 reads outstanding.
REQ-039 SHALL cover len=0: done_o pulse next cycle, ram_cen_o stays 1, valid_o stays 0.
REQ-040 SHALL cover rst asserted after the third transfer of a len=8 burst: all outputs at reset values immediately, no valid_o after release until a new start_i.
REQ-041 SHALL cover start_i pulsed mid-burst and again in the done_o cycle: first ignored, second starts a new burst.
